bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- PIPELINED, default 0: 0 gives read latency 1, 1 gives read latency 2 (matches the attached stall BRAM port).
- ADDR_WIDTH, default 1: address width.
- DATA_WIDTH, default 1: data width.
REQ-002 Clocking and reset SHALL be one clock, CLK; reset is synchronous and active-high, RST.
REQ-003 Ports SHALL be (n = 0,1, one set per requester):
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQn  in  1  request valid
- WEn  in  1  1 = write, 0 = read
- ADDRn  in  ADDR_WIDTH  request address
- DIn  in  DATA_WIDTH  write data
- GNTn  out  1  request accepted this cycle
- RSP_VALIDn  out  1  read data for requester n is on RSP_DATA
- RSP_RDYn  in  1  requester n consumes the response
- RSP_DATA  out  DATA_WIDTH  shared read data, equal to BRAM_DO
- BRAM_EN  out  1  BRAM port enable
- BRAM_WE  out  1  BRAM port write enable
- BRAM_ADDR  out  ADDR_WIDTH  BRAM port address
- BRAM_DI  out  DATA_WIDTH  BRAM port write data
- BRAM_DO  in  DATA_WIDTH  BRAM port read data
- BRAM_DEQ  out  1  BRAM advance pulse without a new access

Function
REQ-004 Tracking: the block SHALL keep a tracking pipe of L = PIPELINED+1 stages, each holding {valid, tag}.
REQ-005 The pipe SHALL shift only when CE = BRAM_EN | BRAM_DEQ is high, mirroring the BRAM clock enable.
REQ-006 Stage 0 SHALL load {1, granted tag} on a read grant, and {0, x} on a write grant or a DEQ.
REQ-007 Head: the head stage SHALL be stage L-1. RSP_VALIDn SHALL be head.valid & (head.tag==n).
REQ-008 Stall: stall SHALL equal head.valid & !RSP_RDY[head.tag]. While stall is high, BRAM_EN, BRAM_DEQ and every GNTn SHALL be 0, so the BRAM and the pipe freeze and RSP_DATA stays stable.
REQ-009 Grant: when not stalled and at least one REQn is high, exactly one GNTn SHALL be 1, chosen per REQ-016/017. The same cycle SHALL drive BRAM_EN=1 and BRAM_WE/ADDR/DI from the winner.
REQ-010 Grant is combinational from REQ and stall: an access is issued in the same cycle it is granted (0-cycle accept).
REQ-011 Drain: when not stalled, no REQn is high and any stage is valid, BRAM_DEQ SHALL be 1. Otherwise BRAM_DEQ SHALL be 0.
REQ-012 Latency: read data SHALL appear at RSP_DATA with RSP_VALIDn high exactly L CE-cycles after grant. With no stall, this is L clock cycles.
REQ-013 A response SHALL be consumed in the cycle where RSP_VALIDn & RSP_RDYn. In that same cycle a new grant SHALL be permitted (full throughput, one access per cycle).
REQ-014 Writes SHALL produce no response. A read to the same address granted after a write SHALL return the written data.
REQ-015 Requesters SHALL hold REQn/WEn/ADDRn/DIn stable until GNTn. The block does not buffer requests.

Configuration
REQ-016 With BRAM_ARB_RR_EN defined, arbitration SHALL be round-robin:
- a 1-bit pointer is updated on each grant to favour the other requester next;
- when both request, the pointer-favoured requester wins.
REQ-017 Without BRAM_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins, and the pointer logic is absent.

Reset
REQ-018 While RST=1 at a CLK edge, all stage valids SHALL clear and the RR pointer SHALL be set to favour requester 0.
REQ-019 During and after reset, until a request arrives, GNTn, RSP_VALIDn, BRAM_EN, BRAM_WE and BRAM_DEQ SHALL be 0. BRAM_ADDR/BRAM_DI are don't-care while BRAM_EN=0.
REQ-020 Reset mid-operation SHALL discard outstanding reads: no RSP_VALID follows for them. The BRAM contents are not affected.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- PIPELINED=0: REQ0 write ADDR=3 DI=0xA5, next cycle REQ0 read ADDR=3 -> GNT0 both cycles; RSP_VALID0=1 with RSP_DATA=0xA5 one cycle after the read grant.
- PIPELINED=1, RSP_RDY0 held 0 for 5 cycles on a pending read -> RSP_VALID0 and RSP_DATA stable; BRAM_EN=BRAM_DEQ=GNT=0 for those 5 cycles; REQ1 not granted until RSP_RDY0=1.
- BRAM_ARB_RR_EN defined, REQ0 and REQ1 both high for 4 cycles -> grants alternate 0,1,0,1. Without the macro -> GNT0 on all 4 cycles.
- Back-to-back reads from both requesters with RSP_RDY=1, PIPELINED=1 -> one grant per cycle; responses return in grant order with correct RSP_VALIDn tags, 2 cycles after each grant.
- Single read then idle, PIPELINED=1 -> BRAM_DEQ=1 on the cycle after the grant; response at cycle+2; BRAM_DEQ=0 afterwards.
- RST asserted with 2 reads outstanding -> no RSP_VALID after reset; the next read returns correct data at latency L.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: arbitrates two requesters onto one BRAM port,
// tracks in-flight reads and back-pressures the BRAM on unconsumed data.
// Ports: CLK, RST (sync, active-high); per requester n=0,1:
//   REQn, WEn, ADDRn, DIn in; GNTn, RSP_VALIDn out; RSP_RDYn in.
//   RSP_DATA out (mirrors BRAM_DO).
//   BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, BRAM_DEQ out; BRAM_DO in.
// Option: define BRAM_ARB_RR_EN for round-robin arbitration,
//   otherwise requester 0 has fixed priority.
module bram_port_arbiter #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  WE0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [DATA_WIDTH-1:0] DI0,
  output logic                  GNT0,
  output logic                  RSP_VALID0,
  input  logic                  RSP_RDY0,
  input  logic                  REQ1,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DI1,
  output logic                  GNT1,
  output logic                  RSP_VALID1,
  input  logic                  RSP_RDY1,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO,
  output logic                  BRAM_DEQ
);

  localparam int L = PIPELINED + 1;

  logic [L-1:0] vld_q, vld_d;
  logic [L-1:0] tag_q, tag_d;

  logic head_vld;
  logic head_tag;
  logic head_rdy;
  logic stall;
  logic blk;
  logic any_req;
  logic win;
  logic win_we;
  logic issue;
  logic rd;
  logic deq;
  logic ce;

  assign head_vld = vld_q[L-1];
  assign head_tag = tag_q[L-1];
  assign head_rdy = head_tag ? RSP_RDY1 : RSP_RDY0;
  assign stall    = head_vld & ~head_rdy;
  // Nothing is issued while in reset so outputs stay quiet.
  assign blk      = stall | RST;
  assign any_req  = REQ0 | REQ1;

`ifdef BRAM_ARB_RR_EN
  // ptr_q names the requester favoured when both request.
  logic ptr_q, ptr_d;

  assign win = (REQ0 & REQ1) ? ptr_q : REQ1;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = ~win;
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  assign win = ~REQ0;
`endif

  assign win_we = win ? WE1 : WE0;
  assign issue  = ~blk & any_req;
  assign rd     = issue & ~win_we;
  assign deq    = ~blk & ~any_req & (|vld_q);
  assign ce     = issue | deq;

  assign GNT0      = issue & ~win;
  assign GNT1      = issue & win;
  assign BRAM_EN   = issue;
  assign BRAM_WE   = issue & win_we;
  assign BRAM_ADDR = win ? ADDR1 : ADDR0;
  assign BRAM_DI   = win ? DI1 : DI0;
  assign BRAM_DEQ  = deq;
  assign RSP_DATA  = BRAM_DO;

  assign RSP_VALID0 = ~RST & head_vld & ~head_tag;
  assign RSP_VALID1 = ~RST & head_vld & head_tag;

  // Tracking pipe advances in lockstep with the BRAM clock enable.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (ce) begin
      for (int i = L - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
      vld_d[0] = rd;
      tag_d[0] = rd & win;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: PIPELINED=0 and PIPELINED=1 instances,
// each with a BRAM model, a transaction-level model and a scoreboard.
module tb_bram_port_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef struct {
    bit            tag;
    logic [DW-1:0] data;
    int            age;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input int inst, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL env%0d %s actual %0h expected %0h",
               inst, nm, act, exp);
    end
  endtask

  task automatic tmo(input int inst, input string nm);
    checks++;
    errors++;
    $display("FAIL env%0d %s bound expired", inst, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int L = g + 1;

    logic          rst, binit;
    logic          req0, we0, rdy0, req1, we1, rdy1;
    logic [AW-1:0] a0, a1, baddr;
    logic [DW-1:0] d0, d1, bdi, bdo, rdata;
    logic          gnt0, gnt1, rv0, rv1, en, bwe, deq;
    bit            mg0, mg1;
    bit            fin = 1'b0;

    bram_port_arbiter #(
      .PIPELINED (g),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
    ) dut (
      .CLK       (clk),
      .RST       (rst),
      .REQ0      (req0),
      .WE0       (we0),
      .ADDR0     (a0),
      .DI0       (d0),
      .GNT0      (gnt0),
      .RSP_VALID0(rv0),
      .RSP_RDY0  (rdy0),
      .REQ1      (req1),
      .WE1       (we1),
      .ADDR1     (a1),
      .DI1       (d1),
      .GNT1      (gnt1),
      .RSP_VALID1(rv1),
      .RSP_RDY1  (rdy1),
      .RSP_DATA  (rdata),
      .BRAM_EN   (en),
      .BRAM_WE   (bwe),
      .BRAM_ADDR (baddr),
      .BRAM_DI   (bdi),
      .BRAM_DO   (bdo),
      .BRAM_DEQ  (deq)
    );

    // BRAM with L output register stages, all gated by EN|DEQ.
    logic [DW-1:0] bmem [16];
    logic [DW-1:0] s1, s2;

    always @(posedge clk) begin
      if (binit) begin
        for (int i = 0; i < 16; i++) bmem[i] <= DW'(i * 37 + g);
      end else if (en || deq) begin
        if (en && bwe)  bmem[baddr] <= bdi;
        if (en && !bwe) s1 <= bmem[baddr];
        s2 <= s1;
      end
    end

    assign bdo = (L == 1) ? s1 : s2;

    // Reference model: reads in flight as a queue with CE ages.
    logic [DW-1:0] mmem [16];
    ent_t pipe_q[$];
    ent_t exp_q[$];
    bit   ptr;

    always @(negedge clk) begin : mdl
      bit hv, ht, st, w, gi, dq, wwe;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      ent_t e;
      if (rst) begin
        pipe_q.delete();
        exp_q.delete();
        ptr = 1'b0;
        if (binit)
          for (int i = 0; i < 16; i++) mmem[i] = DW'(i * 37 + g);
        chk(g, "reset_outputs",
            32'({gnt1, gnt0, en, bwe, deq, rv1, rv0}), 32'(0));
        mg0 = 1'b0;
        mg1 = 1'b0;
      end else begin
        hv = pipe_q.size() > 0 && pipe_q[0].age == L;
        ht = hv ? pipe_q[0].tag : 1'b0;
        st = hv && !(ht ? rdy1 : rdy0);
`ifdef BRAM_ARB_RR_EN
        w = (req0 && req1) ? ptr : req1;
`else
        w = !req0;
`endif
        wwe = w ? we1 : we0;
        wa  = w ? a1 : a0;
        wd  = w ? d1 : d0;
        gi  = !st && (req0 || req1);
        dq  = !st && !(req0 || req1) && pipe_q.size() > 0;
        chk(g, "gnt", 32'({gnt1, gnt0}),
            32'(gi ? (w ? 2'b10 : 2'b01) : 2'b00));
        chk(g, "bram_en", 32'(en), 32'(gi));
        chk(g, "bram_we", 32'(bwe), 32'(gi && wwe));
        chk(g, "bram_deq", 32'(deq), 32'(dq));
        chk(g, "rsp_valid", 32'({rv1, rv0}),
            32'(hv ? (ht ? 2'b10 : 2'b01) : 2'b00));
        if (gi) chk(g, "bram_addr", 32'(baddr), 32'(wa));
        if (gi && wwe) chk(g, "bram_di", 32'(bdi), 32'(wd));
        if (gi || dq) begin
          if (hv) void'(pipe_q.pop_front());
          foreach (pipe_q[i]) pipe_q[i].age++;
          if (gi) begin
            if (wwe) mmem[wa] = wd;
            else begin
              e.tag  = w;
              e.data = mmem[wa];
              e.age  = 1;
              pipe_q.push_back(e);
              exp_q.push_back(e);
            end
            ptr = !w;
          end
        end
        mg0 = gi && !w;
        mg1 = gi && w;
      end
    end

    // Scoreboard monitor: compares every presented response.
    always @(negedge clk) begin
      if (!rst && (rv0 || rv1)) begin
        if (exp_q.size() == 0) begin
          tmo(g, "rsp_unexpected");
        end else begin
          chk(g, "rsp_tag", 32'(rv1), 32'(exp_q[0].tag));
          chk(g, "rsp_data", 32'(rdata), 32'(exp_q[0].data));
          if ((rv0 && rdy0) || (rv1 && rdy1))
            void'(exp_q.pop_front());
        end
      end
    end

    task automatic req_once(input bit n, input bit we,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      int k = 0;
      if (n) begin req1 = 1; we1 = we; a1 = a; d1 = d; end
      else   begin req0 = 1; we0 = we; a0 = a; d0 = d; end
      do begin step(); k++; end
      while (!(n ? mg1 : mg0) && k < 50);
      if (k >= 50) tmo(g, "gnt_wait");
      if (n) req1 = 0;
      else   req0 = 0;
    endtask

    task automatic pump(input int n, input bit rnd);
      int k = 0;
      for (int c = 0; c < n; c++) begin
        if (mg0) req0 = 0;
        if (mg1) req1 = 0;
        if (!req0 && (rnd ? $urandom_range(2) != 0 : c % 2 == 0)) begin
          req0 = 1;
          we0  = rnd ? 1'($urandom_range(1)) : 1'b0;
          a0   = AW'($urandom);
          d0   = DW'($urandom);
        end
        if (!req1 && (!rnd || $urandom_range(2) != 0)) begin
          req1 = 1;
          we1  = rnd ? 1'($urandom_range(1)) : 1'b0;
          a1   = AW'($urandom);
          d1   = DW'($urandom);
        end
        rdy0 = rnd ? ($urandom_range(3) != 0) : 1'b1;
        rdy1 = rnd ? ($urandom_range(3) != 0) : 1'b1;
        step();
      end
      if (mg0) req0 = 0;
      if (mg1) req1 = 0;
      rdy0 = 1;
      rdy1 = 1;
      while ((req0 || req1) && k < 100) begin
        step();
        if (mg0) req0 = 0;
        if (mg1) req1 = 0;
        k++;
      end
      if (k >= 100) tmo(g, "drain");
      repeat (4) step();
    endtask

    task automatic do_reset(input int n);
      rst = 1;
      repeat (n) step();
      rst = 0;
      binit = 0;
    endtask

    initial begin
      int k;
      rst = 1; binit = 1;
      req0 = 0; we0 = 0; a0 = '0; d0 = '0; rdy0 = 1;
      req1 = 0; we1 = 0; a1 = '0; d1 = '0; rdy1 = 1;
      #1;
      do_reset(2);
      repeat (2) step();

      // write then read back from requester 0
      req_once(0, 1, 4'd3, 8'hA5);
      req_once(0, 0, 4'd3, 8'h00);
      repeat (L - 1) step();
      @(negedge clk);
      chk(g, "wr_rd_valid", 32'(rv0), 32'(1));
      chk(g, "wr_rd_data", 32'(rdata), 32'(8'hA5));
      step();

      // single read then idle: DEQ drains the pipe
      req_once(0, 0, 4'd7, 8'h00);
      for (int i = 1; i < L; i++) begin
        @(negedge clk);
        chk(g, "drain_deq", 32'(deq), 32'(1));
        chk(g, "drain_early", 32'(rv0), 32'(0));
        step();
      end
      @(negedge clk);
      chk(g, "drain_rsp", 32'(rv0), 32'(1));
      chk(g, "drain_rsp_deq", 32'(deq), 32'(1));
      step();
      @(negedge clk);
      chk(g, "drain_idle", 32'({deq, rv0}), 32'(0));
      step();

      // stalled response blocks requester 1
      rdy0 = 0;
      req_once(0, 0, 4'd5, 8'h00);
      repeat (L - 1) step();
      req1 = 1; we1 = 0; a1 = 4'd6;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk(g, "stall_quiet", 32'({gnt0, gnt1, en, deq}), 32'(0));
        chk(g, "stall_valid", 32'(rv0), 32'(1));
        step();
      end
      rdy0 = 1;
      k = 0;
      do begin step(); k++; end while (!mg1 && k < 20);
      if (k >= 20) tmo(g, "stall_release");
      req1 = 0;
      repeat (4) step();

      // both requesting: arbitration order
      do_reset(1);
      req0 = 1; we0 = 1; a0 = 4'd1; d0 = 8'h11;
      req1 = 1; we1 = 1; a1 = 4'd2; d1 = 8'h22;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
`ifdef BRAM_ARB_RR_EN
        chk(g, "arb_gnt1", 32'(gnt1), 32'(i % 2));
`else
        chk(g, "arb_gnt1", 32'(gnt1), 32'(0));
`endif
        chk(g, "arb_one_hot", 32'(gnt0 ^ gnt1), 32'(1));
        step();
      end
      req0 = 0; req1 = 0;
      repeat (2) step();

      // back-to-back reads from both requesters
      pump(12, 0);

      // reset with reads outstanding
      req_once(0, 0, 4'd8, 8'h00);
      req_once(0, 0, 4'd9, 8'h00);
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk(g, "post_rst_quiet", 32'({rv1, rv0}), 32'(0));
        step();
      end
      req_once(1, 0, 4'd3, 8'h00);
      repeat (L - 1) step();
      @(negedge clk);
      chk(g, "post_rst_valid", 32'(rv1), 32'(1));
      chk(g, "post_rst_data", 32'(rdata), 32'(8'hA5));
      step();

      // randomized traffic with random back-pressure
      pump(300, 1);
      fin = 1;
    end
  end

  initial begin
    fork
      wait (env[0].fin && env[1].fin);
      begin
        #400000;
        tmo(-1, "global_timeout");
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
